// File: rtl/breadboard_pkg.sv
// ---------------------------------------------------------------------------
// breadboard_pkg
// Shared definitions for the programmable truth-table block:
//   - default function-input count and function count
//   - sweep FSM state encoding
//   - helper returning the number of rows (2^K) of a K-input truth table
// ---------------------------------------------------------------------------
package breadboard_pkg;

    localparam int DEF_K = 4;
    localparam int DEF_F = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of rows in a K-input truth table.
    function automatic int numRows(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/lut_bank.sv
// ---------------------------------------------------------------------------
// lut_bank
// F truth tables of 2^K bits each, held in registers.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset, clears every table
//   i_we    write strobe (caller guarantees i_sel < F when asserted)
//   i_sel   table index to write
//   i_data  new truth table, bit i = f(input == i)
//   i_idx   input vector to look up in all tables
//   o_bits  bit j = table j at row i_idx (combinational read)
// ---------------------------------------------------------------------------
module lut_bank
    import breadboard_pkg::*;
#(
    parameter int K  = DEF_K,
    parameter int F  = DEF_F,
    parameter int SW = (F > 1) ? $clog2(F) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [SW-1:0]           i_sel,
    input  logic [numRows(K)-1:0]   i_data,
    input  logic [K-1:0]            i_idx,
    output logic [F-1:0]            o_bits
);

    localparam int N = numRows(K);

    logic [N-1:0] r_table [F];

    // Table storage. Writes are decoded per table so that the select width
    // never has to match the array depth exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < F; j++) begin
                r_table[j] <= '0;
            end
        end else begin
            for (int j = 0; j < F; j++) begin
                if (i_we && (i_sel == SW'(j))) begin
                    r_table[j] <= i_data;
                end
            end
        end
    end

    // Read one row across all tables. Because the tables are registers, a
    // same-cycle write is not yet visible here (read-before-write).
    always_comb begin
        o_bits = '0;
        for (int j = 0; j < F; j++) begin
            o_bits[j] = r_table[j][i_idx];
        end
    end

endmodule

// File: rtl/breadboard_lut_seq.sv
// ---------------------------------------------------------------------------
// breadboard_lut_seq
// F run-time programmable K-input boolean functions with a registered
// evaluation path and a sweep engine that dumps every input combination.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cfg_we/sel/data   truth-table write port (accepted only in IDLE)
//   o_cfg_err           one-cycle pulse after a rejected write
//   i_in_valid, i_in_vec  evaluate one vector (IDLE only)
//   i_start             begin a full sweep (IDLE only, beats i_in_valid)
//   o_busy              sweep in progress
//   o_done              pulse alongside the last sweep output
//   o_out_valid, o_out_vec, o_out_idx  registered result and its vector
// ---------------------------------------------------------------------------
module breadboard_lut_seq
    import breadboard_pkg::*;
#(
    parameter int K  = DEF_K,
    parameter int F  = DEF_F,
    parameter int SW = (F > 1) ? $clog2(F) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cfg_we,
    input  logic [SW-1:0]           i_cfg_sel,
    input  logic [numRows(K)-1:0]   i_cfg_data,
    output logic                    o_cfg_err,
    input  logic                    i_in_valid,
    input  logic [K-1:0]            i_in_vec,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_out_valid,
    output logic [F-1:0]            o_out_vec,
    output logic [K-1:0]            o_out_idx
);

    // Counter is one bit wider than the index so the terminal value never
    // aliases with a wrapped index.
    localparam logic [K:0] LAST_ROW = (K+1)'(numRows(K) - 1);

    state_t         r_state;
    logic [K:0]     r_cnt;

    logic           w_selInRange;
    logic           w_writeEn;
    logic           w_evalEn;
    logic [K-1:0]   w_evalIdx;
    logic [F-1:0]   w_bits;

    // The select is widened by one bit so an F equal to 2^SW still compares
    // correctly instead of truncating to zero.
    always_comb begin
        w_selInRange = ({1'b0, i_cfg_sel} < (SW+1)'(F));
        w_writeEn    = i_cfg_we && (r_state == IDLE) && w_selInRange;
        w_evalEn     = (r_state == SWEEP) ||
                       ((r_state == IDLE) && i_in_valid && !i_start);
        w_evalIdx    = (r_state == SWEEP) ? r_cnt[K-1:0] : i_in_vec;
    end

    lut_bank #(
        .K  (K),
        .F  (F),
        .SW (SW)
    ) u_bank (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_writeEn),
        .i_sel  (i_cfg_sel),
        .i_data (i_cfg_data),
        .i_idx  (w_evalIdx),
        .o_bits (w_bits)
    );

    // Sweep FSM plus all output registers. done is raised on the edge that
    // enters DRAIN so it lines up with the final sweep output; reset drops
    // straight to IDLE so an aborted sweep never reports done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            o_cfg_err   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_vec   <= '0;
            o_out_idx   <= '0;
        end else begin
            o_cfg_err   <= i_cfg_we && !w_writeEn;
            o_done      <= 1'b0;
            o_out_valid <= w_evalEn;
            if (w_evalEn) begin
                o_out_vec <= w_bits;
                o_out_idx <= w_evalIdx;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (r_cnt == LAST_ROW) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                        o_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_breadboard_lut_seq.sv
// ---------------------------------------------------------------------------
// tb_breadboard_lut_seq
// Directed bench for breadboard_lut_seq (K=4, F=10). Stimulus pushes the
// expected {idx, vec} of every result into a queue; an independent monitor
// pops and compares whenever the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_breadboard_lut_seq;

    localparam int K = 4;
    localparam int F = 10;
    localparam int SW = 4;
    localparam logic [15:0] TAB0 = 16'h6F62;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfgWe;
    logic [SW-1:0]  cfgSel;
    logic [15:0]    cfgData;
    logic           cfgErr;
    logic           inValid;
    logic [K-1:0]   inVec;
    logic           start;
    logic           busy;
    logic           done;
    logic           outValid;
    logic [F-1:0]   outVec;
    logic [K-1:0]   outIdx;

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    logic [K+F-1:0] expQ [$];

    breadboard_lut_seq #(.K(K), .F(F)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_we    (cfgWe),
        .i_cfg_sel   (cfgSel),
        .i_cfg_data  (cfgData),
        .o_cfg_err   (cfgErr),
        .i_in_valid  (inValid),
        .i_in_vec    (inVec),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_out_valid (outValid),
        .o_out_vec   (outVec),
        .o_out_idx   (outIdx)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point for both the stimulus thread and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
        if (outValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedOutput", {18'd0, outIdx, outVec}, 32'hFFFF_FFFF);
            end else begin
                logic [K+F-1:0] exp;
                exp = expQ.pop_front();
                checkOutput("outIdx", 32'(outIdx), 32'(exp[K+F-1:F]));
                checkOutput("outVec", 32'(outVec), 32'(exp[F-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sweep row: f0 from TAB0, f1 all-ones once loaded, f9 all-ones.
    function automatic logic [F-1:0] sweepRow(input int i, input logic tab1Ones);
        logic [15:0] t0;
        t0 = TAB0;
        return {1'b1, 7'd0, tab1Ones, t0[i]};
    endfunction

    task automatic cfgWrite(input logic [SW-1:0] sel, input logic [15:0] data,
                            input logic expErr);
        cfgWe = 1'b1;
        cfgSel = sel;
        cfgData = data;
        tick();
        cfgWe = 1'b0;
        checkOutput("cfgErr", 32'(cfgErr), 32'(expErr));
    endtask

    task automatic applyStimulus(input logic [K-1:0] vec, input logic [F-1:0] expVec);
        inValid = 1'b1;
        inVec = vec;
        expQ.push_back({vec, expVec});
        tick();
        inValid = 1'b0;
    endtask

    // Full sweep with busy/done cycle checks; optional rejected write and a
    // simultaneous in_valid that must be dropped.
    task automatic runSweep(input logic withCfg, input logic withEval,
                            input logic tab1Ones);
        for (int i = 0; i < 16; i++) begin
            expQ.push_back({4'(i), sweepRow(i, tab1Ones)});
        end
        start = 1'b1;
        if (withEval) begin
            inValid = 1'b1;
            inVec = 4'h5;
        end
        tick();
        start = 1'b0;
        inValid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            checkOutput("sweepBusy", 32'(busy), 32'd1);
            checkOutput("sweepDone", 32'(done), 32'(c == 17));
            if (withCfg && c == 4) begin
                checkOutput("cfgErrSweep", 32'(cfgErr), 32'd1);
                cfgWe = 1'b0;
            end
            if (withCfg && c == 3) begin
                cfgWe = 1'b1;
                cfgSel = 4'd1;
                cfgData = 16'hFFFF;
            end
            if (c == 5) begin
                inValid = 1'b1;
                inVec = 4'hC;
            end
            if (c == 6) inValid = 1'b0;
            tick();
        end
        checkOutput("postBusy", 32'(busy), 32'd0);
        checkOutput("postDone", 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cfgWe = 1'b0;
        cfgSel = '0;
        cfgData = '0;
        inValid = 1'b0;
        inVec = '0;
        start = 1'b0;
        tick();
        tick();
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstOutVec", 32'(outVec), 32'd0);
        checkOutput("rstOutIdx", 32'(outIdx), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstCfgErr", 32'(cfgErr), 32'd0);
        rst = 1'b0;
        tick();

        // Cleared tables, then hold behaviour when in_valid drops.
        applyStimulus(4'hA, 10'h000);
        tick();
        checkOutput("holdValid", 32'(outValid), 32'd0);
        checkOutput("holdIdx", 32'(outIdx), 32'hA);

        // f0 = 0x6F62: row 6 is 1, row 7 is 0.
        cfgWrite(4'd0, TAB0, 1'b0);
        applyStimulus(4'h6, 10'h001);
        applyStimulus(4'h7, 10'h000);
        cfgWrite(4'd9, 16'hFFFF, 1'b0);
        applyStimulus(4'h6, 10'h201);
        applyStimulus(4'h7, 10'h200);

        // Out-of-range select is rejected for exactly one cycle.
        cfgWrite(4'd10, 16'h1234, 1'b1);
        tick();
        checkOutput("cfgErrClear", 32'(cfgErr), 32'd0);

        // Sweep with a rejected mid-sweep write, then confirm tables intact.
        runSweep(1'b1, 1'b0, 1'b0);
        runSweep(1'b0, 1'b0, 1'b0);

        // Read-before-write: first sees old table 1, second sees new.
        cfgWe = 1'b1;
        cfgSel = 4'd1;
        cfgData = 16'hFFFF;
        applyStimulus(4'h0, 10'h200);
        cfgWe = 1'b0;
        checkOutput("rbwCfgErr", 32'(cfgErr), 32'd0);
        applyStimulus(4'h0, 10'h202);

        // start and in_valid together: only the sweep happens.
        runSweep(1'b0, 1'b1, 1'b1);

        // Reset during the 5th SWEEP cycle aborts without done.
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({4'(i), sweepRow(i, 1'b1)});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortValid", 32'(outValid), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        tick();
        applyStimulus(4'h6, 10'h000);
        applyStimulus(4'hF, 10'h000);
        applyStimulus(4'h0, 10'h000);
        tick();
        tick();

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("doneCount", 32'(doneCount), 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
